// File: rtl/bcd_conv_scheduler.sv
// Round-robin arbiter sharing one external binary-to-BCD converter between two requesters,
// plus a 2-digit multiplexed display scan with leading-zero blanking.
module bcd_conv_scheduler #(
  parameter int SCAN_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_a,
  input  logic [5:0] val_a,
  output logic       ack_a,
  input  logic       req_b,
  input  logic [5:0] val_b,
  output logic       ack_b,
  output logic [5:0] conv_bin,
  input  logic [3:0] conv_tens,
  input  logic [3:0] conv_ones,
  output logic [7:0] bcd_a,
  output logic [7:0] bcd_b,
  output logic       busy,
  input  logic       disp_sel,
  output logic [3:0] disp_digit,
  output logic [1:0] disp_en
);

  localparam int NUM_REQ = 2;
  localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t state, state_nx;

  // Requester index: 0 = A, 1 = B.
  logic                          grant, last_grant;
  logic                          win, issue_go;
  logic [NUM_REQ-1:0][7:0]       bcd_q;
  logic [NUM_REQ-1:0]            ack_q;
  logic [15:0]                   scan_cnt;
  logic                          digit_ptr;
  logic [7:0]                    src;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    issue_go = 1'b0;
    win      = grant;
    case (state)
      IDLE: begin
        if (req_a || req_b) begin
          issue_go = 1'b1;
          state_nx = ISSUE;
          win      = (req_a && req_b) ? ~last_grant : req_b;
        end
      end
      ISSUE:   state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant      <= 1'b0;
      last_grant <= 1'b1;
      conv_bin   <= '0;
    end else if (issue_go) begin
      grant      <= win;
      last_grant <= win;
      conv_bin   <= win ? val_b : val_a;
    end
  end

  // Per-requester result and ack: captured at the end of ISSUE, once conv_bin has settled.
  for (genvar r = 0; r < NUM_REQ; r++) begin : g_req
    logic hit;
    assign hit = (state == ISSUE) && (grant == 1'(r));
    always_ff @(posedge clk) begin
      if (rst) begin
        bcd_q[r] <= '0;
        ack_q[r] <= 1'b0;
      end else begin
        ack_q[r] <= hit;
        if (hit) bcd_q[r] <= {conv_tens, conv_ones};
      end
    end
  end

  assign ack_a = ack_q[0];
  assign ack_b = ack_q[1];
  assign bcd_a = bcd_q[0];
  assign bcd_b = bcd_q[1];
  assign busy  = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt  <= '0;
      digit_ptr <= 1'b0;
    end else if (scan_cnt == DIV_LAST) begin
      scan_cnt  <= '0;
      digit_ptr <= ~digit_ptr;
    end else begin
      scan_cnt  <= scan_cnt + 16'd1;
    end
  end

  assign src = disp_sel ? bcd_b : bcd_a;

  always_comb begin
    disp_digit = src[3:0];
    disp_en    = 2'b01;
    if (digit_ptr) begin
      if (src[7:4] == 4'd0) begin
        disp_digit = 4'd0;
        disp_en    = 2'b00;
      end else begin
        disp_digit = src[7:4];
        disp_en    = 2'b10;
      end
    end
  end

endmodule

// File: tb/tb_bcd_conv_scheduler.sv
// Directed and randomized checks of bcd_conv_scheduler against a transaction-level model
// (arithmetic BCD, round-robin fairness, bounded latency).
module tb_bcd_conv_scheduler;
  localparam int SCAN_DIV = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_a, req_b, ack_a, ack_b, busy, disp_sel;
  logic [5:0] val_a, val_b, conv_bin;
  logic [3:0] conv_tens, conv_ones, disp_digit;
  logic [7:0] bcd_a, bcd_b;
  logic [1:0] disp_en;

  int checks = 0;
  int errors = 0;

  bcd_conv_scheduler #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .val_a(val_a), .ack_a(ack_a),
    .req_b(req_b), .val_b(val_b), .ack_b(ack_b),
    .conv_bin(conv_bin), .conv_tens(conv_tens), .conv_ones(conv_ones),
    .bcd_a(bcd_a), .bcd_b(bcd_b), .busy(busy),
    .disp_sel(disp_sel), .disp_digit(disp_digit), .disp_en(disp_en)
  );

  always #5 clk = ~clk;

  // External converter model.
  always_comb begin
    conv_tens = 4'(conv_bin / 6'd10);
    conv_ones = 4'(conv_bin % 6'd10);
  end

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int  wait_a, wait_b, pass_a, pass_b, ph;
    logic found;
    wait_a = 0; wait_b = 0; pass_a = 0; pass_b = 0;

    // Reset with both requests pending.
    rst = 1'b1; disp_sel = 1'b0;
    req_a = 1'b1; req_b = 1'b1; val_a = 6'd21; val_b = 6'd42;
    tick; tick;
    chk("rst_busy", busy, 0);
    chk("rst_ack_a", ack_a, 0);
    chk("rst_ack_b", ack_b, 0);
    chk("rst_bcd_a", bcd_a, 0);
    chk("rst_bcd_b", bcd_b, 0);
    chk("rst_conv_bin", conv_bin, 0);
    chk("rst_disp_en", disp_en, 2'b01);
    chk("rst_disp_digit", disp_digit, 0);
    rst = 1'b0;
    tick;
    chk("rst_first_conv_bin", conv_bin, 21);
    tick;
    chk("rst_first_ack_a", ack_a, 1);
    chk("rst_first_ack_b", ack_b, 0);
    chk("rst_first_bcd_a", bcd_a, 8'h21);
    req_a = 1'b0; req_b = 1'b0;
    tick;
    chk("rst_first_idle", busy, 0);

    // Single request from A.
    val_a = 6'd45; req_a = 1'b1;
    tick;
    chk("single_conv_bin", conv_bin, 45);
    chk("single_busy1", busy, 1);
    tick;
    chk("single_ack_a", ack_a, 1);
    chk("single_bcd_a", bcd_a, 8'h45);
    chk("single_busy2", busy, 1);
    req_a = 1'b0;
    tick;
    chk("single_idle", busy, 0);
    chk("single_ack_drop", ack_a, 0);
    chk("single_conv_hold", conv_bin, 45);

    // Single request from B (makes B the most recent grant).
    val_b = 6'd27; req_b = 1'b1;
    tick; tick;
    chk("single_b_ack", ack_b, 1);
    chk("single_b_bcd", bcd_b, 8'h27);
    req_b = 1'b0;
    tick;

    // Contention, each side dropping req on its ack.
    val_a = 6'd63; val_b = 6'd9; req_a = 1'b1; req_b = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick;
      chk($sformatf("cont_ack_a_c%0d", c), ack_a, c == 2);
      chk($sformatf("cont_ack_b_c%0d", c), ack_b, c == 5);
      if (c == 2) begin chk("cont_bcd_a", bcd_a, 8'h63); req_a = 1'b0; end
      if (c == 5) begin chk("cont_bcd_b", bcd_b, 8'h09); req_b = 1'b0; end
    end
    tick;

    // Sustained requests: acks alternate A, B, A, B every 3 cycles.
    req_a = 1'b1; req_b = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick;
      chk($sformatf("sust_ack_a_c%0d", c), ack_a, (c == 2) || (c == 8));
      chk($sformatf("sust_ack_b_c%0d", c), ack_b, (c == 5) || (c == 11));
    end
    req_a = 1'b0; req_b = 1'b0;
    tick;

    // Reset during ISSUE.
    val_a = 6'd50; req_a = 1'b1;
    tick;
    chk("mid_busy", busy, 1);
    rst = 1'b1;
    tick;
    chk("mid_ack_a", ack_a, 0);
    chk("mid_bcd_a", bcd_a, 0);
    chk("mid_bcd_b", bcd_b, 0);
    chk("mid_idle", busy, 0);
    rst = 1'b0;
    tick;
    chk("mid_retry_conv_bin", conv_bin, 50);
    tick;
    chk("mid_retry_ack_a", ack_a, 1);
    chk("mid_retry_bcd_a", bcd_a, 8'h50);
    req_a = 1'b0;
    tick;

    // Load display values: bcd_a = 37, bcd_b = 05.
    val_a = 6'd37; req_a = 1'b1;
    tick; tick;
    req_a = 1'b0;
    tick;
    val_b = 6'd5; req_b = 1'b1;
    tick; tick;
    chk("disp_load_b", bcd_b, 8'h05);
    req_b = 1'b0;
    tick;

    // Scan of A: align to the first cycle of a ones phase.
    disp_sel = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 2 * SCAN_DIV + 2 && !found; i++) begin
      tick;
      if (disp_en == 2'b10) found = 1'b1;
    end
    chk("disp_a_find_tens", found, 1);
    found = 1'b0;
    for (int i = 0; i < 2 * SCAN_DIV + 2 && !found; i++) begin
      tick;
      if (disp_en == 2'b01) found = 1'b1;
    end
    chk("disp_a_find_ones", found, 1);
    for (int i = 0; i < 4 * SCAN_DIV; i++) begin
      ph = (i / SCAN_DIV) % 2;
      chk($sformatf("disp_a_en_%0d", i), disp_en, ph ? 2'b10 : 2'b01);
      chk($sformatf("disp_a_digit_%0d", i), disp_digit, ph ? 3 : 7);
      tick;
    end

    // disp_sel acts combinationally; B's tens digit is blanked.
    disp_sel = 1'b1;
    #1;
    chk("disp_sel_comb_digit", disp_digit, 5);
    chk("disp_sel_comb_en", disp_en, 2'b01);
    found = 1'b0;
    for (int i = 0; i < 2 * SCAN_DIV + 2 && !found; i++) begin
      tick;
      if (disp_en == 2'b00) found = 1'b1;
    end
    chk("disp_b_find_blank", found, 1);
    found = 1'b0;
    for (int i = 0; i < 2 * SCAN_DIV + 2 && !found; i++) begin
      tick;
      if (disp_en == 2'b01) found = 1'b1;
    end
    chk("disp_b_find_ones", found, 1);
    for (int i = 0; i < 2 * SCAN_DIV; i++) begin
      ph = (i / SCAN_DIV) % 2;
      chk($sformatf("disp_b_en_%0d", i), disp_en, ph ? 2'b00 : 2'b01);
      chk($sformatf("disp_b_digit_%0d", i), disp_digit, ph ? 0 : 5);
      tick;
    end
    disp_sel = 1'b0;

    // Random traffic: correct BCD, exclusive acks, bounded wait, round-robin fairness.
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!req_a && $urandom_range(0, 2) == 0) begin
        req_a = 1'b1; val_a = 6'($urandom_range(0, 63)); wait_a = 0; pass_a = 0;
      end
      if (!req_b && $urandom_range(0, 2) == 0) begin
        req_b = 1'b1; val_b = 6'($urandom_range(0, 63)); wait_b = 0; pass_b = 0;
      end
      tick;
      if (req_a) wait_a++;
      if (req_b) wait_b++;
      chk("rnd_ack_excl", ack_a & ack_b, 0);
      if (ack_a) begin
        chk("rnd_ack_a_req", req_a, 1);
        chk("rnd_bcd_a", bcd_a, to_bcd(val_a));
        chk("rnd_wait_a", wait_a <= 6, 1);
        chk("rnd_pass_a", pass_a <= 1, 1);
        if (req_b) pass_b++;
        if ($urandom_range(0, 1) == 1) begin
          val_a = 6'($urandom_range(0, 63)); wait_a = 0; pass_a = 0;
        end else req_a = 1'b0;
      end
      if (ack_b) begin
        chk("rnd_ack_b_req", req_b, 1);
        chk("rnd_bcd_b", bcd_b, to_bcd(val_b));
        chk("rnd_wait_b", wait_b <= 6, 1);
        chk("rnd_pass_b", pass_b <= 1, 1);
        if (req_a) pass_a++;
        if ($urandom_range(0, 1) == 1) begin
          val_b = 6'($urandom_range(0, 63)); wait_b = 0; pass_b = 0;
        end else req_b = 1'b0;
      end
    end
    req_a = 1'b0; req_b = 1'b0;
    tick; tick; tick; tick;
    chk("rnd_final_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bcd_conv_scheduler.md
Name: bcd_conv_scheduler

Overview:
- Shares one combinational 6-bit binary-to-2-digit-BCD converter between two requesters (A, B) using round-robin arbitration and a req/ack handshake.
- Holds the latest BCD result for each requester.
- Drives a time-multiplexed 2-digit display scan of either result, with leading-zero blanking.
- Sits between the value sources (counters/switch logic) and the display drivers. The converter instance is external and connects through the conv_* ports.

Parameters:
- SCAN_DIV, 4: clock cycles each display digit stays enabled. Legal range is 1 to 65535.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  synchronous, active-high reset.
- req_a  in  1  requester A conversion request.
- val_a  in  6  requester A binary value, 0..63.
- ack_a  out  1  one-cycle pulse: bcd_a updated.
- req_b  in  1  requester B conversion request.
- val_b  in  6  requester B binary value.
- ack_b  out  1  one-cycle pulse: bcd_b updated.
- conv_bin  out  6  value driven to the shared converter.
- conv_tens  in  4  converter tens digit.
- conv_ones  in  4  converter ones digit.
- bcd_a  out  8  {tens,ones} latest result for A.
- bcd_b  out  8  {tens,ones} latest result for B.
- busy  out  1  high when the FSM is not IDLE.
- disp_sel  in  1  0 = display bcd_a, 1 = display bcd_b.
- disp_digit  out  4  BCD digit currently scanned.
- disp_en  out  2  one-hot digit enable: bit0 = ones, bit1 = tens. Active-high.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values:
  - state = IDLE; conv_bin = 0; bcd_a = bcd_b = 0; ack_a = ack_b = 0.
  - last_grant = B, so A wins the first tie.
  - Scan counter = 0, digit pointer = 0 (ones).
  - disp_en = 01, disp_digit = 0.
- FSM states IDLE, ISSUE, DONE, all transitions registered:
  - IDLE:
    - No req: stay in IDLE.
    - Any req: go to ISSUE, record the grant, and load conv_bin with the winner's val.
    - Only one req high: grant it.
    - Both high: grant the requester that is not last_grant, then update last_grant.
  - ISSUE: conv_bin is held stable for one cycle so the converter settles. At the end of the cycle:
    - load the winner's bcd register with {conv_tens, conv_ones};
    - set the winner's ack;
    - go to DONE.
  - DONE: ack is high for exactly this cycle and req inputs are ignored. Go to IDLE.
- Latency and throughput:
  - req sampled in IDLE at cycle 0.
  - conv_bin valid during cycle 1.
  - ack and new bcd visible in cycle 2.
  - Re-arbitration in cycle 3. Maximum throughput is one conversion per 3 cycles.
- Handshake rules:
  - Requester holds req and val until it sees ack, then may drop req or keep it for a new conversion.
  - val changes after the grant cycle are ignored because conv_bin is latched.
  - A req still high in IDLE after its ack starts a new conversion.
- ack_a and ack_b are never high in the same cycle.
- conv_bin holds the last issued value while in IDLE.
- bcd_x changes only in the cycle its ack rises, or on reset.
- Reset mid-operation (ISSUE or DONE):
  - abort to IDLE, no ack, bcd regs cleared;
  - the requester must keep req asserted to be served.
- Display scan:
  - The counter counts 0..SCAN_DIV-1. On wrap it returns to 0 and toggles the digit pointer.
  - SCAN_DIV = 1 toggles the pointer every cycle.
  - Source register is bcd_b if disp_sel = 1, else bcd_a. disp_sel may change at any time and takes effect combinationally on disp_digit.
  - Pointer 0: disp_digit = source[3:0], disp_en = 01.
  - Pointer 1: disp_digit = source[7:4], disp_en = 10.
  - Pointer 1 with source[7:4] = 0: disp_en = 00 (leading-zero blanking), disp_digit = 0.
  - Scanning runs independently of the FSM and continues while busy.

Test Plan:
- Reset: hold rst 2 cycles with reqs high.
  - Required: all outputs at reset values, busy = 0, no ack.
  - After release, A is served first.
- Single request: req_a = 1, val_a = 45 in IDLE at cycle 0.
  - Required: conv_bin = 45 in cycle 1; ack_a = 1 and bcd_a = 8'h45 in cycle 2; busy = 1 in cycles 1-2.
- Contention: req_a = 1 (val 63) and req_b = 1 (val 9) together, each dropping req on its ack.
  - Required: ack_a in cycle 2 with bcd_a = 8'h63; ack_b in cycle 5 with bcd_b = 8'h09; never both acks high.
- Sustained requests: both reqs held high for 12 cycles.
  - Required: acks alternate A, B, A, B, with 3 cycles between consecutive acks.
- Reset mid-conversion: assert rst during ISSUE of an A request.
  - Required: no ack_a, bcd_a = 0, state IDLE.
  - Re-asserted request completes normally.
- Display: SCAN_DIV = 4, bcd_a = 8'h37, disp_sel = 0.
  - Required: 4 cycles of en = 01 / digit 7, then 4 cycles of en = 10 / digit 3, repeating.
  - With bcd_b = 8'h05 and disp_sel = 1: tens phase gives en = 00.
